// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framer: command encodings,
// opcode bytes, per-command frame counts and the serializer state type.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_REG_WRITE   = 2'd0,
        CMD_REG_READ    = 2'd1,
        CMD_ALU_WITH_OP = 2'd2,
        CMD_ALU_NO_OP   = 2'd3
    } cmd_type_e;

    localparam logic [7:0] OPC_REG_WRITE   = 8'hAA;
    localparam logic [7:0] OPC_REG_READ    = 8'hBB;
    localparam logic [7:0] OPC_ALU_WITH_OP = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO_OP   = 8'hDD;

    localparam int LEN_REG_WRITE   = 3;
    localparam int LEN_REG_READ    = 2;
    localparam int LEN_ALU_WITH_OP = 4;
    localparam int LEN_ALU_NO_OP   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Leading opcode byte of each command.
    function automatic logic [7:0] cmd_opcode(input cmd_type_e typ);
        logic [7:0] opc;
        case (typ)
            CMD_REG_WRITE:   opc = OPC_REG_WRITE;
            CMD_REG_READ:    opc = OPC_REG_READ;
            CMD_ALU_WITH_OP: opc = OPC_ALU_WITH_OP;
            default:         opc = OPC_ALU_NO_OP;
        endcase
        return opc;
    endfunction

    // Index of the final byte of a command (frame count minus one).
    function automatic logic [1:0] cmd_last_idx(input cmd_type_e typ);
        logic [1:0] last;
        case (typ)
            CMD_REG_WRITE:   last = 2'(LEN_REG_WRITE - 1);
            CMD_REG_READ:    last = 2'(LEN_REG_READ - 1);
            CMD_ALU_WITH_OP: last = 2'(LEN_ALU_WITH_OP - 1);
            default:         last = 2'(LEN_ALU_NO_OP - 1);
        endcase
        return last;
    endfunction

    // Byte number idx of a command's on-line sequence.
    function automatic logic [7:0] cmd_byte(input cmd_type_e  typ,
                                            input logic [1:0] idx,
                                            input logic [7:0] addr,
                                            input logic [7:0] wdata,
                                            input logic [7:0] opa,
                                            input logic [7:0] opb,
                                            input logic [7:0] func);
        logic [7:0] b;
        case (idx)
            2'd0:    b = cmd_opcode(typ);
            2'd1:    b = (typ == CMD_ALU_WITH_OP) ? opa :
                         (typ == CMD_ALU_NO_OP)   ? func : addr;
            2'd2:    b = (typ == CMD_REG_WRITE) ? wdata : opb;
            default: b = func;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Single-byte UART serializer: start bit, data LSB first, optional parity,
// one stop bit. A new byte can be taken in the last stop-bit cycle so that
// consecutive frames follow with no idle gap.
module uart_frame_tx
    import uart_cmd_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_byte_valid,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_byte_ready,
    output logic                  o_frame_done,
    output logic                  o_tx
);

    localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_WIDTH - 1);

    tx_state_e             r_state;
    logic [7:0]            r_presc;
    logic [2:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;

    tx_state_e             w_state_next;
    logic [2:0]            w_bit_next;
    logic                  w_tx_next;
    logic                  w_tick;
    logic                  w_byte_ready;
    logic                  w_load;

    assign w_tick       = (r_state != ST_IDLE) && (r_presc == PRESC_MAX);
    assign w_byte_ready = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick);
    assign w_load       = i_byte_valid && w_byte_ready;

    assign o_byte_ready = w_byte_ready;
    assign o_frame_done = (r_state == ST_STOP) && w_tick;
    assign o_tx         = r_tx;

    // Next-state, next bit index and next line level.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        w_state_next = r_state;
        w_bit_next   = r_bit_idx;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_load) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT)
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                    else
                        w_bit_next = r_bit_idx + 3'd1;
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) w_state_next = w_load ? ST_START : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_data[w_bit_next];
            ST_PARITY: w_tx_next = r_par_bit;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // State, bit timing and byte/parity capture registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: every register, including the data byte, is cleared by the async reset so the line idles high immediately.
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_next;
            r_tx      <= w_tx_next;
            r_presc   <= ((r_state == ST_IDLE) || w_tick) ? 8'd0 : r_presc + 8'd1;
            if (w_load) begin
                r_data    <= i_byte;
                r_par_en  <= i_par_en;
                r_par_bit <= (^i_byte) ^ i_par_typ;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// Command framer: latches one descriptor per handshake and feeds its byte
// sequence to the serializer, reporting busy/done around the whole command.
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [7:0]            CMD_WDATA,
    input  logic [7:0]            CMD_OPA,
    input  logic [7:0]            CMD_OPB,
    input  logic [3:0]            CMD_FUNC,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_done;
    cmd_type_e             r_type;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wdata;
    logic [7:0]            r_opa;
    logic [7:0]            r_opb;
    logic [3:0]            r_func;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [1:0]            r_byte_idx;
    logic [1:0]            r_last_idx;

    logic                  w_accept;
    logic                  w_more;
    logic                  w_byte_valid;
    logic [7:0]            w_byte;
    logic                  w_par_en;
    logic                  w_par_typ;
    logic                  w_frame_done;
    logic                  w_byte_ready;

    assign w_accept     = CMD_VALID && r_cmd_ready;
    assign w_more       = r_busy && (r_byte_idx != r_last_idx);
    assign w_byte_valid = w_accept || w_more;

    // The opcode goes out straight from the inputs on the accepting edge so
    // the start bit appears in the next cycle; later bytes come from the latch.
    assign w_byte    = w_accept
                     ? cmd_opcode(cmd_type_e'(CMD_TYPE))
                     : cmd_byte(r_type, r_byte_idx + 2'd1, 8'(r_addr), r_wdata,
                                r_opa, r_opb, 8'(r_func));
    assign w_par_en  = w_accept ? PAR_EN  : r_par_en;
    assign w_par_typ = w_accept ? PAR_TYP : r_par_typ;

    uart_frame_tx #(
        .PRESCALE   (PRESCALE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_frame_tx (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_byte_valid (w_byte_valid),
        .i_byte       (w_byte),
        .i_par_en     (w_par_en),
        .i_par_typ    (w_par_typ),
        .o_byte_ready (w_byte_ready),
        .o_frame_done (w_frame_done),
        .o_tx         (TX_OUT)
    );

    assign CMD_READY = r_cmd_ready;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

    // Descriptor latch, byte-index sequencer and command status flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_type      <= CMD_REG_WRITE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_func      <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_byte_idx  <= '0;
            r_last_idx  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_type      <= cmd_type_e'(CMD_TYPE);
                r_addr      <= CMD_ADDR;
                r_wdata     <= CMD_WDATA;
                r_opa       <= CMD_OPA;
                r_opb       <= CMD_OPB;
                r_func      <= CMD_FUNC;
                r_par_en    <= PAR_EN;
                r_par_typ   <= PAR_TYP;
                r_byte_idx  <= '0;
                r_last_idx  <= cmd_last_idx(cmd_type_e'(CMD_TYPE));
                r_cmd_ready <= 1'b0;
                r_busy      <= 1'b1;
            end else if (r_busy && w_frame_done) begin
                if (r_byte_idx == r_last_idx) begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: a per-cycle line model built from the command
// byte tables, plus directed commands decoded mid-bit against literal bytes.
module tb_uart_cmd_framer;

    localparam int P = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_TYPE = 2'd0;
    logic [3:0] CMD_ADDR = 4'd0;
    logic [7:0] CMD_WDATA = 8'd0;
    logic [7:0] CMD_OPA = 8'd0;
    logic [7:0] CMD_OPB = 8'd0;
    logic [3:0] CMD_FUNC = 4'd0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;
    logic cap[$];

    uart_cmd_framer #(.PRESCALE(P), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .CMD_OPA   (CMD_OPA),
        .CMD_OPB   (CMD_OPB),
        .CMD_FUNC  (CMD_FUNC),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected line level for every remaining cycle of the current command.
    logic m_q[$];
    logic m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_done = 1'b0;

    function automatic void m_build(input logic [1:0] t, input logic [3:0] addr,
                                    input logic [7:0] wd, input logic [7:0] a,
                                    input logic [7:0] b, input logic [3:0] f,
                                    input logic pe, input logic pt);
        logic [7:0] bl[$];
        case (t)
            2'd0:    bl = '{8'hAA, {4'h0, addr}, wd};
            2'd1:    bl = '{8'hBB, {4'h0, addr}};
            2'd2:    bl = '{8'hCC, a, b, {4'h0, f}};
            default: bl = '{8'hDD, {4'h0, f}};
        endcase
        foreach (bl[k]) begin
            logic [7:0] v;
            v = bl[k];
            repeat (P) m_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (P) m_q.push_back(v[i]);
            if (pe) repeat (P) m_q.push_back((^v) ^ pt);
            repeat (P) m_q.push_back(1'b1);
        end
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_ready && CMD_VALID) begin
                m_build(CMD_TYPE, CMD_ADDR, CMD_WDATA, CMD_OPA, CMD_OPB, CMD_FUNC, PAR_EN, PAR_TYP);
                m_tx = m_q.pop_front();
                m_busy = 1'b1; m_ready = 1'b0;
            end else if (m_busy) begin
                if (m_q.size() > 0) m_tx = m_q.pop_front();
                else begin
                    m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_tx", TX_OUT, m_tx);
            check("cyc_busy", BUSY, m_busy);
            check("cyc_ready", CMD_READY, m_ready);
            check("cyc_done", DONE, m_done);
        end
    end

    always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                         input logic pe, input logic pt);
        CMD_TYPE = t; CMD_ADDR = addr; CMD_WDATA = wd; CMD_OPA = a; CMD_OPB = b;
        CMD_FUNC = f; PAR_EN = pe; PAR_TYP = pt; CMD_VALID = 1'b1;
    endtask

    // Called on the negedge of the first start-bit cycle; records the line
    // until DONE and returns the number of cycles recorded.
    task automatic capture(input int budget, output int n);
        cap.delete();
        n = -1;
        for (int i = 0; i < budget; i++) begin
            if (DONE === 1'b1) begin
                n = i;
                break;
            end
            cap.push_back(TX_OUT);
            @(negedge CLK);
        end
        if (n < 0) begin
            n_chk++; n_err++;
            $display("FAIL done_timeout: no DONE within %0d cycles", budget);
        end
    endtask

    // Mid-bit UART decode of the captured line.
    task automatic decode(input string tag, input int nb, input logic pe,
                          input logic [7:0] eb[4], input logic ep[4]);
        int flen, base;
        logic [7:0] got;
        flen = (10 + (pe ? 1 : 0)) * P;
        for (int f = 0; f < nb; f++) begin
            base = f * flen;
            check({tag, "_start"}, cap[base + P/2], 1'b0);
            for (int i = 0; i < 8; i++) got[i] = cap[base + (1 + i) * P + P/2];
            check({tag, "_byte"}, got, eb[f]);
            if (pe) check({tag, "_parity"}, cap[base + 9 * P + P/2], ep[f]);
            check({tag, "_stop"}, cap[base + (9 + (pe ? 1 : 0)) * P + P/2], 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0;
        #1 RST = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // 1: reset then idle
        check("rst_tx", TX_OUT, 1'b1);
        check("rst_ready", CMD_READY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        repeat (100) @(negedge CLK);
        check("idle_tx", TX_OUT, 1'b1);

        // 2: REG_WRITE with even parity
        issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("wr_tx_low", TX_OUT, 1'b0);
        check("wr_busy", BUSY, 1'b1);
        check("wr_ready", CMD_READY, 1'b0);
        CMD_ADDR = 4'hA; CMD_WDATA = 8'hFF;
        capture(2000, n);
        check("wr_len", n, 264);
        decode("wr", 3, 1'b1, '{8'hAA, 8'h05, 8'h3C, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0});
        check("wr_end_busy", BUSY, 1'b0);
        check("wr_end_ready", CMD_READY, 1'b1);
        check("wr_end_tx", TX_OUT, 1'b1);
        repeat (3) @(negedge CLK);

        // 3: REG_READ with odd parity
        issue(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        capture(2000, n);
        check("rd_len", n, 176);
        decode("rd", 2, 1'b1, '{8'hBB, 8'h0F, 8'h00, 8'h00}, '{1'b1, 1'b1, 1'b0, 1'b0});
        repeat (3) @(negedge CLK);

        // 4: ALU_WITH_OP without parity
        issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, 1'b0, 1'b0);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        capture(2000, n);
        check("alu_len", n, 320);
        decode("alu", 4, 1'b0, '{8'hCC, 8'h12, 8'h34, 8'h02}, '{1'b0, 1'b0, 1'b0, 1'b0});
        repeat (3) @(negedge CLK);

        // 5: back-to-back, CMD_VALID held; inputs change after first acceptance
        d0 = done_cnt;
        issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0);
        @(negedge CLK);
        CMD_TYPE = 2'd1; CMD_ADDR = 4'h1; CMD_FUNC = 4'h0; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        capture(2000, n);
        check("b2b1_len", n, 160);
        decode("b2b1", 2, 1'b0, '{8'hDD, 8'h07, 8'h00, 8'h00}, '{1'b0, 1'b0, 1'b0, 1'b0});
        check("b2b_gap_tx", TX_OUT, 1'b1);
        @(negedge CLK);
        check("b2b_restart_tx", TX_OUT, 1'b0);
        check("b2b_restart_busy", BUSY, 1'b1);
        CMD_VALID = 1'b0;
        capture(2000, n);
        check("b2b2_len", n, 176);
        decode("b2b2", 2, 1'b1, '{8'hBB, 8'h01, 8'h00, 8'h00}, '{1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge CLK);
        check("b2b_done_pulses", done_cnt - d0, 2);
        repeat (3) @(negedge CLK);

        // 6: reset during DATA of frame 2
        issue(2'd0, 4'h2, 8'h5A, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (100) @(negedge CLK);
        d0 = done_cnt;
        #2 RST = 1'b1;
        #1;
        check("mid_rst_tx", TX_OUT, 1'b1);
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_ready", CMD_READY, 1'b1);
        check("mid_rst_done", DONE, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(negedge CLK);
        check("mid_rst_no_done", done_cnt, d0);
        issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 1'b1, 1'b1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        capture(2000, n);
        check("post_rst_len", n, 176);
        decode("post_rst", 2, 1'b1, '{8'hDD, 8'h0A, 8'h00, 8'h00}, '{1'b1, 1'b1, 1'b0, 1'b0});
        repeat (5) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
Host-side command generator that sits directly upstream of the system's RX_IN serial input. It accepts one command descriptor per valid/ready handshake and expands it into the byte sequence the system controller decodes. Each byte is serialized as a UART frame: start bit, 8 data bits LSB first, optional parity, one stop bit. The block is used as an on-chip stimulus/loopback source and as the bench driver for the full system.

Parameters:
PRESCALE, 8, CLK cycles per serial bit (legal range 1..255)
DATA_WIDTH, 8, UART data bits per frame (fixed at 8; no other value is supported)
ADDR_WIDTH, 4, register-file address width, zero-extended to 8 bits on the line

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command descriptor valid
CMD_READY  output  1  block can accept a command
CMD_TYPE  input  2  0=REG_WRITE, 1=REG_READ, 2=ALU_WITH_OP, 3=ALU_NO_OP
CMD_ADDR  input  ADDR_WIDTH  register address
CMD_WDATA  input  8  register write data
CMD_OPA  input  8  ALU operand A
CMD_OPB  input  8  ALU operand B
CMD_FUNC  input  4  ALU function, zero-extended to 8 bits
PAR_EN  input  1  parity bit present when 1
PAR_TYP  input  1  0=even, 1=odd
TX_OUT  output  1  serial line toward the system's RX_IN; idles high
BUSY  output  1  command in progress
DONE  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values: TX_OUT=1, BUSY=0, DONE=0, CMD_READY=1. All outputs are registered.
- RST assertion mid-command: the command is discarded immediately and asynchronously; TX_OUT=1; no DONE is issued.
- Acceptance: a command is accepted when CMD_VALID & CMD_READY at a rising edge. On acceptance the block latches all CMD_* fields, PAR_EN and PAR_TYP. Input changes after acceptance are ignored until the next acceptance.
- Byte sequences, sent in this order:
  - REG_WRITE: 0xAA, addr, wdata (3 frames)
  - REG_READ: 0xBB, addr (2 frames)
  - ALU_WITH_OP: 0xCC, opA, opB, func (4 frames)
  - ALU_NO_OP: 0xDD, func (2 frames)
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after PRESCALE cycles.
  - DATA -> PARITY after 8 bits if PAR_EN latched, otherwise DATA -> STOP.
  - PARITY -> STOP after PRESCALE cycles.
  - STOP -> START if more bytes remain, otherwise STOP -> IDLE.
- Bit timing: every bit is held exactly PRESCALE cycles. A frame lasts (10+PAR_EN)*PRESCALE cycles. There is no idle gap between frames of the same command.
- Parity: even parity = XOR of the 8 data bits; odd parity = its inverse.
- Latency: TX_OUT falls (start bit) in the cycle after acceptance. CMD_READY=0 and BUSY=1 from that same cycle.
- Completion: after the final stop-bit cycle, DONE pulses for 1 cycle, BUSY=0, CMD_READY=1 and state returns to IDLE.
- Back-to-back commands: if CMD_VALID is held, the next command is accepted in the first IDLE cycle. The line therefore idles high for at least one cycle between commands.
- Counters:
  - Prescale counter wraps at PRESCALE-1.
  - Bit index runs 0..7.
  - Byte index runs 0..len-1, where len is 2, 3 or 4 from CMD_TYPE.
  - No counter overflows beyond these bounds.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - opcode constants 0xAA, 0xBB, 0xCC, 0xDD
  - CMD_TYPE encodings
  - per-type frame-length constants
  - FSM state encoding
- One natural sub-module, uart_frame_tx: a single-byte serializer with BYTE_VALID/BYTE_READY, parity control and the START/DATA/PARITY/STOP timing.
- The top-level uart_cmd_framer then reduces to the descriptor latch, byte mux and byte-index sequencer.

Test Plan:
1. Reset then idle: RST pulse, no commands -> TX_OUT=1, CMD_READY=1, BUSY=0 for 100 cycles.
2. REG_WRITE, addr 5, wdata 0x3C, PAR_EN=1, PAR_TYP=0, PRESCALE=8 -> frames 0xAA/0x05/0x3C, each with parity bit 0. Each frame is 88 cycles, so 264 cycles total. DONE fires 264 cycles after the first start-bit cycle; a bench UART decoder sampling mid-bit matches all bytes.
3. REG_READ, addr 0xF, PAR_EN=1, PAR_TYP=1 -> frames 0xBB (parity 1) and 0x0F (parity 1). Total 176 cycles.
4. ALU_WITH_OP, A=0x12, B=0x34, func=0x2, PAR_EN=0 -> frames 0xCC/0x12/0x34/0x02, each 80 cycles (320 total). No parity bit is present.
5. Back-to-back commands: ALU_NO_OP func=0x7 with CMD_VALID held, followed by REG_READ addr 1 -> both sequences are sent in order. Exactly one high idle cycle separates them, and DONE pulses twice.
6. Reset mid-command: RST asserted during the DATA state of frame 2 -> TX_OUT=1 immediately and no DONE. After release a new command frames correctly from its first byte.
